// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver for the scl/sda serial link.
// Detects START/STOP, reassembles DATA_W-bit words, and flags malformed frames.
module sipo_rx #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda,
  output logic [DATA_W-1:0] data,
  output logic              d_valid,
  output logic              err,
  output logic [3:0]        state
);

  localparam int unsigned CW = $clog2(DATA_W + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_RECV = 4'd1,
    S_WAIT = 4'd2
  } state_e;

  state_e            state_q;
  logic              scl_q;
  logic              sda_q;
  logic              scl_d;
  logic              sda_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] data_q;
  logic              dv_q;
  logic              err_q;

  logic              ev_start;
  logic              ev_stop;
  logic              ev_bit;
  logic              last_bit;
  logic [DATA_W-1:0] shreg_nx;

  assign ev_start = scl_d & scl_q & sda_d & ~sda_q;
  assign ev_stop  = scl_d & scl_q & ~sda_d & sda_q;
  assign ev_bit   = ~scl_d & scl_q;
  assign last_bit = (cnt_q == CW'(DATA_W - 1));
  // Truncation keeps the low DATA_W bits, so the first bit ends as MSB.
  assign shreg_nx = DATA_W'({shreg_q, sda_q});

  always_ff @(posedge sclk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
      scl_d <= scl_q;
      sda_d <= sda_q;
      dv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ev_start) begin
            state_q <= S_RECV;
            cnt_q   <= '0;
            shreg_q <= '0;
          end
        end
        S_RECV: begin
          if (ev_start) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            shreg_q <= '0;
          end else if (ev_stop) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (ev_bit) begin
            shreg_q <= shreg_nx;
            if (last_bit) begin
              cnt_q   <= '0;
              state_q <= S_WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (ev_stop) begin
            data_q  <= shreg_q;
            dv_q    <= 1'b1;
            state_q <= S_IDLE;
          end else if (ev_bit) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (ev_start) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            shreg_q <= '0;
            state_q <= S_RECV;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data    = data_q;
  assign d_valid = dv_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule
